// File: rtl/seq_multiplier_param_if.sv
// seq_multiplier_param_if: start/busy/done handshake and operand/product bus
// for the parametrised sequential multiplier.
interface seq_multiplier_param_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: shift-add multiplier, one multiplier bit per clock.
// Unsigned or two's-complement (SIGNED), operands WIDTH bits, product 2*WIDTH.
// Optional SEQ_MULT_EARLY_DONE_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (data-dependent latency, same products).
module seq_multiplier_param #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_multiplier_param_if.slave bus
);
    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_q, sign_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   final_val;
    logic [WIDTH-1:0]     b_shift;
    logic                 last_cycle;
    logic                 capture;

    // Operand magnitudes and per-cycle datapath values
    always_comb begin
        a_neg     = (SIGNED != 0) && bus.multiplicand[WIDTH-1];
        b_neg     = (SIGNED != 0) && bus.multiplier[WIDTH-1];
        a_mag     = a_neg ? (WIDTH'(0) - bus.multiplicand) : bus.multiplicand;
        b_mag     = b_neg ? (WIDTH'(0) - bus.multiplier)   : bus.multiplier;
        acc_sum   = acc_q + (b_q[0] ? a_q : '0);
        b_shift   = b_q >> 1;
        final_val = sign_q ? ((2*WIDTH)'(0) - acc_sum) : acc_sum;
`ifdef SEQ_MULT_EARLY_DONE_EN
        last_cycle = (cnt_q == CNT_LAST) || (b_shift == '0);
`else
        last_cycle = (cnt_q == CNT_LAST);
`endif
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) capture = 1'b1;
            end
            S_RUN: begin
                acc_d = acc_sum;
                a_d   = a_q << 1;
                b_d   = b_shift;
                cnt_d = cnt_q + CW'(1);
                if (last_cycle) begin
                    state_d   = S_DONE;
                    product_d = final_val;
                end
            end
            S_DONE: begin
                if (bus.start) capture = 1'b1;
                else           state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            state_d = S_RUN;
            a_d     = {{WIDTH{1'b0}}, a_mag};
            b_d     = b_mag;
            acc_d   = '0;
            cnt_d   = '0;
            sign_d  = a_neg ^ b_neg;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
        end
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// tb_seq_multiplier_param: directed vectors on an unsigned and a signed
// WIDTH=8 instance; expected products/done cycles go into per-DUT queues
// and a negedge monitor checks each done pulse against them.
module tb_seq_multiplier_param;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_multiplier_param_if #(.WIDTH(W)) bus0 ();
    seq_multiplier_param_if #(.WIDTH(W)) bus1 ();

    seq_multiplier_param #(.WIDTH(W), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .bus(bus0));
    seq_multiplier_param #(.WIDTH(W), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t           q0[$];
    exp_t           q1[$];
    int             cyc    = 0;
    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] prev [2];
    logic           done_d0 = 1'b0;
    logic           done_d1 = 1'b0;

    // Rising-edge counter used as the time base for expected done cycles
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(input int sel, input logic [2*W-1:0] p, input int c);
        exp_t x;
        x.prod = p;
        x.cyc  = c;
        if (sel == 0) q0.push_back(x);
        else          q1.push_back(x);
    endtask

    task automatic drive(input int sel, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (sel == 0) begin
            bus0.start = s; bus0.multiplicand = a; bus0.multiplier = b;
        end else begin
            bus1.start = s; bus1.multiplicand = a; bus1.multiplier = b;
        end
    endtask

    task automatic check_out(input int sel, input logic busy, input logic done,
                             input logic done_prev, input logic [2*W-1:0] prod);
        exp_t e;
        checks++;
        if (busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap dut%0d cyc=%0d busy=%0b done=%0b required not both", sel, cyc, busy, done);
        end
        checks++;
        if (done && done_prev) begin
            errors++;
            $display("FAIL done_two_cycles dut%0d cyc=%0d required single-cycle pulse", sel, cyc);
        end
        if (done) begin
            checks++;
            if (qsize(sel) == 0) begin
                errors++;
                $display("FAIL unexpected_done dut%0d cyc=%0d product=%0h required no done", sel, cyc, prod);
            end else begin
                if (sel == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                if (prod !== e.prod) begin
                    errors++;
                    $display("FAIL product dut%0d cyc=%0d got=%h required=%h", sel, cyc, prod, e.prod);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_cycle dut%0d got=%0d required=%0d", sel, cyc, e.cyc);
                end
            end
        end
    endtask

    // Monitor: every done pulse is matched against the scoreboard queues
    always @(negedge clk) begin
        check_out(0, bus0.busy, bus0.done, done_d0, bus0.product);
        check_out(1, bus1.busy, bus1.done, done_d1, bus1.product);
        done_d0 = bus0.done;
        done_d1 = bus1.done;
    end

    task automatic wait_drain(input int sel);
        int n;
        n = 0;
        while (qsize(sel) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (qsize(sel) != 0) begin
            errors++;
            $display("FAIL done_timeout dut%0d pending=%0d required=0", sel, qsize(sel));
            if (sel == 0) q0.delete();
            else          q1.delete();
        end
    endtask

    function automatic int pick_lat(input int lf, input int le);
`ifdef SEQ_MULT_EARLY_DONE_EN
        return le;
`else
        return lf;
`endif
    endfunction

    // Single operation: busy window and held product checked each cycle
    task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] p, input int lf, input int le);
        int             e;
        int             lat;
        logic [2*W-1:0] held;
        logic           bz;
        logic [2*W-1:0] pr;
        lat  = pick_lat(lf, le);
        held = prev[sel];
        @(negedge clk);
        e = cyc + 1;
        drive(sel, 1'b1, a, b);
        push(sel, p, e + lat);
        @(negedge clk);
        drive(sel, 1'b0, ~a, ~b);
        while (cyc < e + lat) begin
            bz = (sel == 0) ? bus0.busy    : bus1.busy;
            pr = (sel == 0) ? bus0.product : bus1.product;
            checks++;
            if (bz !== 1'b1) begin
                errors++;
                $display("FAIL busy_run dut%0d cyc=%0d got=%b required=1", sel, cyc, bz);
            end
            checks++;
            if (pr !== held) begin
                errors++;
                $display("FAIL product_held dut%0d cyc=%0d got=%h required=%h", sel, cyc, pr, held);
            end
            @(negedge clk);
        end
        bz = (sel == 0) ? bus0.busy : bus1.busy;
        checks++;
        if (bz !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done dut%0d cyc=%0d got=%b required=0", sel, cyc, bz);
        end
        prev[sel] = p;
        wait_drain(sel);
    endtask

    task automatic check_idle(input string nm, input int sel);
        logic           bz;
        logic           dn;
        logic [2*W-1:0] pr;
        bz = (sel == 0) ? bus0.busy    : bus1.busy;
        dn = (sel == 0) ? bus0.done    : bus1.done;
        pr = (sel == 0) ? bus0.product : bus1.product;
        checks++;
        if (bz !== 1'b0 || dn !== 1'b0 || pr !== '0) begin
            errors++;
            $display("FAIL %s dut%0d busy=%b done=%b product=%h required busy=0 done=0 product=0",
                     nm, sel, bz, dn, pr);
        end
    endtask

    // Global time bound
    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    // Directed stimulus
    initial begin
        int e;
        int lat1;
        int lat2;
        prev[0] = '0;
        prev[1] = '0;
        rst = 1'b1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check_idle("reset_state", 0);
        check_idle("reset_state", 1);
        rst = 1'b0;

        // Unsigned vectors: sel, A, B, product, fixed latency, early latency
        run_op(0, 8'd13,  8'd11,  16'd143,   8, 4);
        run_op(0, 8'd255, 8'd255, 16'hFE01,  8, 8);
        run_op(0, 8'd0,   8'd200, 16'd0,     8, 8);
        run_op(0, 8'd7,   8'd0,   16'd0,     8, 1);
        run_op(0, 8'd9,   8'd5,   16'd45,    8, 3);
        run_op(0, 8'd3,   8'd128, 16'd384,   8, 8);

        // Signed vectors
        run_op(1, 8'h80, 8'h80, 16'h4000, 8, 8);
        run_op(1, 8'hF9, 8'd6,  16'hFFD6, 8, 3);
        run_op(1, 8'd127, 8'hFF, 16'hFF81, 8, 1);
        run_op(1, 8'hFD, 8'hFB, 16'd15,   8, 3);

        // Back-to-back with start held high: 3*4 then 5*6
        lat1 = pick_lat(8, 3);
        lat2 = pick_lat(8, 3);
        @(negedge clk);
        e = cyc + 1;
        drive(0, 1'b1, 8'd3, 8'd4);
        push(0, 16'd12, e + lat1);
        @(negedge clk);
        drive(0, 1'b1, 8'd5, 8'd6);
        push(0, 16'd30, e + lat1 + 1 + lat2);
        while (cyc < e + lat1 + 1) @(negedge clk);
        drive(0, 1'b0, 8'd0, 8'd0);
        wait_drain(0);
        prev[0] = 16'd30;

        // Start pulse during RUN must be ignored: only 2*3 completes
        lat1 = pick_lat(8, 2);
        @(negedge clk);
        e = cyc + 1;
        drive(0, 1'b1, 8'd2, 8'd3);
        push(0, 16'd6, e + lat1);
        @(negedge clk);
        drive(0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        drive(0, 1'b1, 8'd100, 8'd100);
        @(negedge clk);
        drive(0, 1'b0, 8'd0, 8'd0);
        wait_drain(0);
        repeat (12) @(negedge clk);
        prev[0] = 16'd6;

        // Reset three cycles into RUN aborts 9*9 with no done pulse
        @(negedge clk);
        e = cyc + 1;
        drive(0, 1'b1, 8'd9, 8'd9);
        @(negedge clk);
        drive(0, 1'b0, 8'd0, 8'd0);
        while (cyc < e + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_reset", 0);
        check_idle("abort_reset", 1);
        rst = 1'b0;
        prev[0] = '0;
        prev[1] = '0;
        repeat (10) @(negedge clk);

        // Fresh operations after the abort
        run_op(0, 8'd9,  8'd9, 16'd81,   8, 4);
        run_op(1, 8'hFE, 8'd3, 16'hFFFA, 8, 2);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_multiplier_param.md
# seq_multiplier_param

Parametrised sequential shift-add multiplier, the next generation of the team's 8×8 datapath multiplier. It multiplies two WIDTH-bit operands, unsigned or two's-complement, in one multiplier bit per clock. It exposes a clean start/busy/done handshake, so a controller can launch back-to-back operations. Product is registered and held stable between operations.

## Interface
- WIDTH, 8, operand width; legal range 2..32
- SIGNED, 0, 0 = unsigned operands/product; 1 = two's-complement operands/product
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled on rising clk
- multiplicand  in  WIDTH  operand A; captured on the accepting edge only
- multiplier  in  WIDTH  operand B; captured on the accepting edge only
- busy  out  1  high while an operation is in progress (state RUN)
- done  out  1  one-cycle pulse; product valid and final
- product  out  2*WIDTH  result register; holds last result until next completion

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: start=1 → capture operands, clear accumulator and bit counter, go RUN. start=0 → stay.
- Capture: A is loaded into a 2*WIDTH shift-left register, zero-extended; B is loaded into a WIDTH shift-right register.
- SIGNED=1: A and B are replaced by their magnitudes at capture. The result sign, A[MSB]^B[MSB], is latched. Magnitude of the most-negative value, 2^(WIDTH-1), fits in WIDTH unsigned bits.
- RUN, each cycle:
  - If the B register LSB is 1, the accumulator gets the accumulator plus the A register, mod 2^(2*WIDTH). No overflow is possible.
  - Shift A left by 1 and B right by 1; the counter increments.
- RUN exit: the counter reaches WIDTH-1 on the current cycle (WIDTH RUN cycles total) → go DONE. On that same edge, product gets the final accumulator value, two's-complement negated if SIGNED=1 and the latched sign is 1.
- DONE: done=1 for exactly one cycle.
  - start=1 → capture new operands, go RUN (back-to-back).
  - start=0 → go IDLE.
- start while in RUN is ignored; operands are not re-captured.
- product changes only on the RUN→DONE edge and on reset. Input operands may change freely after capture.

## Timing
- Reset values: busy=0, done=0, product=0. The accumulator, shift registers, counter and sign latch are cleared.
- rst has priority over every transition. Asserting rst mid-RUN aborts the operation: no done pulse, product=0 on the next cycle.
- Latency, fixed mode: start accepted on edge E → busy=1 after E → done=1 and product valid after edge E+WIDTH → busy=0 from that same edge.
- Throughput, back-to-back: one result per WIDTH+1 cycles (start held high or re-asserted during DONE).
- busy and done are never both high. done never stays high for 2 consecutive cycles.

## Configuration
- SEQ_MULT_EARLY_DONE_EN defined: RUN exits on the first cycle where the post-shift B register is zero, or the counter reaches WIDTH-1, whichever comes first.
  - Latency = max(1, k) cycles, where k = index of the highest set bit of |B|, plus 1.
  - B=0 → done after edge E+1.
  - Product values are identical to the fixed-latency mode.
- Not defined: always WIDTH RUN cycles. No data-dependent timing.

## Test plan
- WIDTH=8, SIGNED=0: A=13, B=11 started at edge E → done after E+8, product=143; busy high for edges E+1..E+8 only.
- WIDTH=8, SIGNED=0: A=255, B=255 → product=65025 (0xFE01); then A=0, B=200 → product=0, with the previous product held until completion.
- WIDTH=8, SIGNED=1:
  - A=-128, B=-128 → product=16384 (0x4000)
  - A=-7, B=6 → product=-42 (0xFFD6)
  - A=127, B=-1 → product=-127 (0xFF81)
- Back-to-back: start held high; A=3, B=4 then A=5, B=6 → done pulses 9 cycles apart, product=12 then 30. A start pulse during RUN is ignored.
- rst asserted 3 cycles into RUN with A=9, B=9 → no done pulse; product=0, busy=0 next cycle; a fresh start works normally.
- SEQ_MULT_EARLY_DONE_EN, WIDTH=8:
  - B=0 → done after E+1
  - B=5 → done after E+3, product=5*A
  - B=128 → done after E+8
  - Same tests without the macro → all done after E+8.
